// File: rtl/div_issue_queue.sv
// Issue queue in front of a combinational divider: buffers operand pairs, issues one at a time,
// resolves divide-by-zero locally and holds each result until downstream accepts it.
module div_issue_queue #(
    parameter int N     = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N-1:0]             in_a,
    input  logic [N-1:0]             in_b,
    output logic                     div_start,
    output logic [N-1:0]             div_a,
    output logic [N-1:0]             div_b,
    input  logic [N-1:0]             div_m,
    input  logic [N-1:0]             div_r,
    input  logic                     div_valid,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N-1:0]             out_q,
    output logic [N-1:0]             out_r,
    output logic                     out_dz,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    memA_q [DEPTH];
    logic [N-1:0]    memB_q [DEPTH];
    logic [PW-1:0]   wrPtr_q, rdPtr_q;
    logic [CW-1:0]   count_q;
    logic [N-1:0]    opA_q, opB_q;
    logic [N-1:0]    resQ_q, resR_q;
    logic            resDz_q;

    logic            push, pop, capture;
    logic [N-1:0]    capQ, capR;
    logic            capDz;

    assign in_ready  = (count_q < CW'(DEPTH));
    assign push      = in_valid && in_ready;
    assign div_start = (state_q == ISSUE) && (opB_q != '0);
    assign div_a     = opA_q;
    assign div_b     = opB_q;
    assign out_valid = (state_q == DONE);
    assign out_q     = resQ_q;
    assign out_r     = resR_q;
    assign out_dz    = resDz_q;
    assign count     = count_q;

    always_ff @(posedge clk) begin
        if (push) begin
            memA_q[wrPtr_q] <= in_a;
            memB_q[wrPtr_q] <= in_b;
        end
    end

    // Pop decisions look only at pre-edge occupancy, so a fresh push is never bypassed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (push) wrPtr_q <= wrPtr_q + PW'(1);
            if (pop)  rdPtr_q <= rdPtr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        capture = 1'b0;
        capQ    = div_m;
        capR    = div_r;
        capDz   = 1'b0;
        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (opB_q == '0) begin
                    capture = 1'b1;
                    capQ    = '1;
                    capR    = opA_q;
                    capDz   = 1'b1;
                    state_d = DONE;
                end else if (div_valid) begin
                    capture = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    if (count_q != '0) begin
                        pop     = 1'b1;
                        state_d = ISSUE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            opA_q   <= '0;
            opB_q   <= '0;
            resQ_q  <= '0;
            resR_q  <= '0;
            resDz_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (pop) begin
                opA_q <= memA_q[rdPtr_q];
                opB_q <= memB_q[rdPtr_q];
            end
            if (capture) begin
                resQ_q  <= capQ;
                resR_q  <= capR;
                resDz_q <= capDz;
            end
        end
    end

endmodule
